fwd_lookup_dispatch: RTL
========================

# fwd_lookup_dispatch

Request-side front end for the forwarding table. Accepts packet-header lookup requests on a valid/ready handshake and drives the table's unthrottled key port. Pairs each in-order table result with the request's tag and resolves miss and special-key outcomes to concrete ports. Returns routed responses on a second valid/ready handshake. Credit-limits issue so no table result is ever dropped, because the table has no backpressure.

## Interface
- WIDTH, 64, key width; equals the table's WIDTH.
- NUM_PORTS, SN_NUM_PORTS, port count; EPW = $clog2(NUM_PORTS).
- TAG_WIDTH, 16, opaque request tag width.
- DEPTH, 8, maximum outstanding lookups; power of two, ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  lookup request valid
- req_ready  out  1  request accepted when high with req_valid
- req_key  in  WIDTH  key to look up
- req_tag  in  TAG_WIDTH  tag returned with the result
- key_valid_out  out  1  to table key_valid_in
- key_check_out  out  WIDTH  to table key_check_in
- endpoint_valid_in  in  1  from table endpoint_valid_out
- endpoint_in  in  EPW  from table endpoint_out
- endpoint_missed_in  in  1  from table endpoint_missed_out
- endpoint_special_in  in  1  from table endpoint_special_matched
- default_endpoint_in  in  EPW  port used on miss; quasi-static
- local_endpoint_in  in  EPW  port used on special match; quasi-static
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_tag  out  TAG_WIDTH  tag of the response
- rsp_endpoint  out  EPW  resolved port
- rsp_missed  out  1  table missed; default port used
- rsp_special  out  1  special key matched; local port used
- protocol_err  out  1  sticky; table result arrived with no outstanding tag

## Operation
- Credit counter `outstanding` has width $clog2(DEPTH)+1.
  - Increments on request handshake; decrements on response handshake; both in the same cycle leaves it unchanged.
  - req_ready = (outstanding < DEPTH); it is a function of registered state only, never of rsp_ready.
- On request handshake:
  - req_tag is pushed into the tag FIFO.
  - key_valid_out <= 1 and key_check_out <= req_key, registered.
  - Otherwise key_valid_out <= 0 and key_check_out <= 0.
- On endpoint_valid_in, the resolved result is pushed into the result FIFO. Resolution priority:
  - endpoint_special_in: endpoint = local_endpoint_in, special = 1, missed = 0.
  - else endpoint_missed_in: endpoint = default_endpoint_in, missed = 1.
  - else endpoint = endpoint_in, both flags 0.
- Results are in order. The response pairs the tag FIFO head with the result FIFO head.
- rsp_valid = result FIFO non-empty. Both FIFOs pop on response handshake.
- rsp_* fields are held stable while rsp_valid && !rsp_ready.
- Error case: endpoint_valid_in while result count equals tag count.
  - The result is dropped and protocol_err is set; it stays set until reset.
- Full/empty: credits guarantee neither FIFO overflows. At outstanding == DEPTH, req_ready = 0 until a response handshake occurs.

## Timing
- Reset values:
  - req_ready = 1.
  - key_valid_out = 0, key_check_out = 0.
  - rsp_valid = 0; rsp_tag, rsp_endpoint, rsp_missed, rsp_special = 0.
  - protocol_err = 0.
  - Both FIFOs empty; outstanding = 0.
- Request handshake in cycle T:
  - key_valid_out is high in T+1.
  - The table result arrives in T+4.
  - rsp_valid is high in T+5 when the result FIFO was empty. Minimum latency is 5 cycles.
- Throughput is 1 request/cycle while credits remain. With rsp_ready held at 1, DEPTH ≥ 6 sustains full rate.
- Reset mid-operation clears all in-flight state. The table shares rst, so no stale results arrive after reset.

## Configuration
- FWD_LOOKUP_STATS_EN defined:
  - Adds outputs stat_hit, stat_miss, stat_special, 32 bits each.
  - Each counts results pushed, by resolved category; counts wrap at 2^32.
  - All reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package SiliconNetTypes: SN_NUM_PORTS and the endpoint typedef. Add typedef FWD_RESULT, a packed struct {endpoint, missed, special}, for the result FIFO entry.
- Sub-module fwd_lookup_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH; async reset.
  - Ports: push, pop, full, empty, count.
  - Instantiated twice: tag FIFO and result FIFO.

## Test plan
- Single request: key 0x0A00_0001, tag 0x0011, table hit endpoint 3, rsp_ready = 1 → rsp_valid in T+5 with tag 0x0011, endpoint 3, missed 0, special 0.
- Miss: default_endpoint_in = 7, table misses → endpoint 7, missed 1.
- Special match together with a hit on endpoint 2, local_endpoint_in = 5 → endpoint 5, special 1, missed 0.
- Backpressure: rsp_ready = 0, DEPTH + 2 requests offered → exactly DEPTH accepted; req_ready = 0 from the cycle after the DEPTH-th handshake. Releasing rsp_ready drains tags in issue order.
- Spurious endpoint_valid_in pulse with no outstanding request → protocol_err = 1 and stays set; no rsp_valid.
- Reset asserted with 4 requests in flight → all outputs return to reset values; no responses after deassert; a new request completes normally.

Source files
------------

// File: rtl/fwd_lookup_dispatch_pkg.sv
// Shared forwarding-table types: port count, endpoint type and the
// resolved-result record carried by the dispatch result FIFO.
package SiliconNetTypes;

  localparam int unsigned SN_NUM_PORTS = 8;
  localparam int unsigned SN_EPW       = $clog2(SN_NUM_PORTS);

  typedef logic [SN_EPW-1:0] endpoint_t;

  typedef struct packed {
    endpoint_t endpoint;
    logic      missed;
    logic      special;
  } FWD_RESULT;

endpackage

// File: rtl/fwd_lookup_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth, async reset.
module fwd_lookup_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/fwd_lookup_dispatch.sv
// Forwarding-table request front end: credit-limited issue, in-order tag/result
// pairing, miss/special resolution. Optional counters under FWD_LOOKUP_STATS_EN.
module fwd_lookup_dispatch
  import SiliconNetTypes::*;
#(
  parameter  int unsigned WIDTH     = 64,
  parameter  int unsigned NUM_PORTS = SN_NUM_PORTS,
  parameter  int unsigned TAG_WIDTH = 16,
  parameter  int unsigned DEPTH     = 8,
  localparam int unsigned EPW       = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_key,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 key_valid_out,
  output logic [WIDTH-1:0]     key_check_out,
  input  logic                 endpoint_valid_in,
  input  logic [EPW-1:0]       endpoint_in,
  input  logic                 endpoint_missed_in,
  input  logic                 endpoint_special_in,
  input  logic [EPW-1:0]       default_endpoint_in,
  input  logic [EPW-1:0]       local_endpoint_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic [EPW-1:0]       rsp_endpoint,
  output logic                 rsp_missed,
  output logic                 rsp_special,
  output logic                 protocol_err
`ifdef FWD_LOOKUP_STATS_EN
  ,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_special
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = $bits(FWD_RESULT);

  logic [CW-1:0]        r_outstanding;
  logic                 r_key_valid;
  logic [WIDTH-1:0]     r_key_check;
  logic                 r_protocol_err;

  logic                 w_req_fire;
  logic                 w_rsp_fire;
  logic                 w_err_evt;
  logic                 w_res_push;
  FWD_RESULT            w_res_in;
  FWD_RESULT            w_res_out;
  logic [TAG_WIDTH-1:0] w_tag_head;
  logic                 w_tag_full;
  logic                 w_tag_empty;
  logic [CW-1:0]        w_tag_count;
  logic                 w_res_full;
  logic                 w_res_empty;
  logic [CW-1:0]        w_res_count;

  assign req_ready  = (r_outstanding < CW'(DEPTH));
  assign w_req_fire = req_valid && req_ready;
  assign w_rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_req_fire && !w_rsp_fire) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_req_fire && w_rsp_fire) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_check <= '0;
    end else if (w_req_fire) begin
      r_key_valid <= 1'b1;
      r_key_check <= req_key;
    end else begin
      r_key_valid <= 1'b0;
      r_key_check <= '0;
    end
  end

  assign key_valid_out = r_key_valid;
  assign key_check_out = r_key_check;

  // Special match outranks miss; a hit passes the table's endpoint through.
  always_comb begin
    w_res_in          = '0;
    w_res_in.endpoint = endpoint_in;
    if (endpoint_special_in) begin
      w_res_in.endpoint = local_endpoint_in;
      w_res_in.special  = 1'b1;
    end else if (endpoint_missed_in) begin
      w_res_in.endpoint = default_endpoint_in;
      w_res_in.missed   = 1'b1;
    end
  end

  // A result with every issued tag already matched has no owner.
  assign w_err_evt  = endpoint_valid_in && (w_res_count == w_tag_count);
  assign w_res_push = endpoint_valid_in && !w_err_evt && !w_res_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_err_evt) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign protocol_err = r_protocol_err;

  fwd_lookup_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_req_fire && !w_tag_full),
    .din   (req_tag),
    .pop   (w_rsp_fire),
    .dout  (w_tag_head),
    .full  (w_tag_full),
    .empty (w_tag_empty),
    .count (w_tag_count)
  );

  fwd_lookup_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_res_push),
    .din   (w_res_in),
    .pop   (w_rsp_fire),
    .dout  (w_res_out),
    .full  (w_res_full),
    .empty (w_res_empty),
    .count (w_res_count)
  );

  // Fields are zeroed while idle so unwritten FIFO storage never leaks out.
  assign rsp_valid    = !w_res_empty && !w_tag_empty;
  assign rsp_tag      = rsp_valid ? w_tag_head : '0;
  assign rsp_endpoint = rsp_valid ? w_res_out.endpoint : '0;
  assign rsp_missed   = rsp_valid && w_res_out.missed;
  assign rsp_special  = rsp_valid && w_res_out.special;

`ifdef FWD_LOOKUP_STATS_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;
  logic [31:0] r_stat_special;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hit     <= '0;
      r_stat_miss    <= '0;
      r_stat_special <= '0;
    end else if (w_res_push) begin
      if (w_res_in.special)     r_stat_special <= r_stat_special + 32'd1;
      else if (w_res_in.missed) r_stat_miss    <= r_stat_miss + 32'd1;
      else                      r_stat_hit     <= r_stat_hit + 32'd1;
    end
  end

  assign stat_hit     = r_stat_hit;
  assign stat_miss    = r_stat_miss;
  assign stat_special = r_stat_special;
`endif

endmodule
